cpu_run_ctrl: RTL
=================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: CPU address/PC width.
REQ-002 SHALL have parameter NUM_VEC, default 4: number of selectable boot vectors (power of 2, >=2).
REQ-003 SHALL have parameter BASE_VEC, default 32'h00000028: boot vector 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 32'h00000100: spacing between boot vectors.
REQ-005 SHALL have parameter RST_CYCLES, default 2: cycles cpu_reset is held after start (>=1).
REQ-006 SHALL have parameter CNT_W, default 32: width of cycle counter and limit.
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse; begins a boot/run sequence.
REQ-010 boot_sel  in  log2(NUM_VEC)  boot vector index, sampled on start.
REQ-011 step_mode  in  1  1 = single-step, sampled on start.
REQ-012 step  in  1  one-cycle pulse; grants one CPU clock-enable cycle in step mode.
REQ-013 halt  in  1  CPU reports halt instruction retired.
REQ-014 cycle_limit  in  CNT_W  max run cycles; 0 = unlimited; sampled on start.
REQ-015 cpu_reset  out  1  reset to CPU core.
REQ-016 cpu_en  out  1  CPU clock enable.
REQ-017 init  out  WIDTH  boot PC to CPU.
REQ-018 busy  out  1  sequence in progress.
REQ-019 done  out  1  sticky: run ended by halt.
REQ-020 timeout  out  1  sticky: run ended by cycle_limit.
REQ-021 cycles  out  CNT_W  count of cycles with cpu_en=1 in current run.

Function
REQ-022 SHALL implement states IDLE, HOLD, RUN, STEP, END.
REQ-023 IDLE: cpu_reset=1, cpu_en=0, busy=0; start -> HOLD, latch boot_sel/step_mode/cycle_limit, clear done/timeout/cycles.
REQ-024 init SHALL equal BASE_VEC + boot_sel_latched*VEC_STRIDE, truncated to WIDTH, registered, stable from HOLD entry until next start.
REQ-025 HOLD: cpu_reset=1, cpu_en=0 for exactly RST_CYCLES cycles, then -> RUN (step_mode=0) or STEP (step_mode=1).
REQ-026 RUN: cpu_reset=0, cpu_en=1 every cycle; cycles increments each cycle.
REQ-027 STEP: cpu_reset=0; cpu_en=1 for exactly the cycle after each step pulse, else 0; cycles increments only on enabled cycles.
REQ-028 halt sampled only while cpu_en=1; halt -> END with done=1, cpu_en=0 the following cycle.
REQ-029 cycle_limit!=0 and cycles reaching cycle_limit -> END with timeout=1; CPU receives exactly cycle_limit enabled cycles.
REQ-030 halt and limit in same cycle: done=1, timeout=0 (halt wins).
REQ-031 END: cpu_reset=0, cpu_en=0, busy=0, CPU state preserved; start -> HOLD (restart).
REQ-032 start while busy (HOLD/RUN/STEP) SHALL restart: -> HOLD, relatch inputs, clear flags and cycles.
REQ-033 cycles SHALL saturate at all-ones, never wrap.
REQ-034 step pulses outside STEP ignored; back-to-back step pulses yield one enabled cycle each.
REQ-035 busy=1 exactly in HOLD, RUN, STEP.

Reset
REQ-036 reset SHALL asynchronously force IDLE, cpu_reset=1, cpu_en=0, init=BASE_VEC, busy=0, done=0, timeout=0, cycles=0.
REQ-037 reset mid-run SHALL abort with no flag set; deassertion returns to IDLE awaiting start.

Structure
REQ-038 State encoding enum and default constants (BASE_VEC, VEC_STRIDE) SHALL live in shared package cpu_run_pkg.
REQ-039 Saturating counter SHALL be sub-module sat_counter (CNT_W, clear, enable).
REQ-040 All outputs SHALL be registered.

Verification
REQ-041 start, boot_sel=0, step_mode=0, limit=0 -> cpu_reset high 2 cycles, init=0x28, then cpu_en=1; halt at cycle 10 -> done=1, cycles=10.
REQ-042 start, boot_sel=3 -> init=0x328.
REQ-043 limit=5, no halt -> exactly 5 cpu_en cycles, timeout=1, done=0, cycles=5.
REQ-044 step_mode=1, three step pulses spaced 4 cycles -> three single cpu_en cycles, cycles=3.
REQ-045 halt and limit coincide at cycle 5 -> done=1, timeout=0.
REQ-046 reset asserted mid-RUN (async, between edges) -> outputs immediately at reset values; start mid-RUN -> re-enter HOLD, cycles=0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared state encoding and default boot-vector constants for cpu_run_ctrl
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_STEP,
        ST_END
    } run_state_t;

    localparam logic [31:0] DEF_BASE_VEC   = 32'h0000_0028;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0100;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - boot/run sequencer: CPU reset hold, free-run or single-step, halt and cycle-limit stop
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          NUM_VEC    = 4,
    parameter logic [31:0] BASE_VEC   = DEF_BASE_VEC,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int          RST_CYCLES = 2,
    parameter int          CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(NUM_VEC)-1:0] boot_sel,
    input  logic                       step_mode,
    input  logic                       step,
    input  logic                       halt,
    input  logic [CNT_W-1:0]           cycle_limit,
    output logic                       cpu_reset,
    output logic                       cpu_en,
    output logic [WIDTH-1:0]           init,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [CNT_W-1:0]           cycles
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t        state;
    logic [CNT_W-1:0]  lim;
    logic              mode;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WIDTH-1:0]  vec_addr;
    logic              limit_hit;

    assign vec_addr = WIDTH'(BASE_VEC) + WIDTH'(VEC_STRIDE) * WIDTH'(boot_sel);

    // cycles still excludes the current enabled cycle, so the limit trips one count early
    assign limit_hit = (lim != '0) && (cycles == lim - CNT_W'(1));

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .enable(cpu_en),
        .count (cycles)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cpu_reset <= 1'b1;
            cpu_en    <= 1'b0;
            init      <= WIDTH'(BASE_VEC);
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            lim       <= '0;
            mode      <= 1'b0;
            hold_cnt  <= '0;
        end else if (start) begin
            state     <= ST_HOLD;
            cpu_reset <= 1'b1;
            cpu_en    <= 1'b0;
            init      <= vec_addr;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            lim       <= cycle_limit;
            mode      <= step_mode;
            hold_cnt  <= HOLD_W'(RST_CYCLES - 1);
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= mode ? ST_STEP : ST_RUN;
                        cpu_reset <= 1'b0;
                        cpu_en    <= !mode;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                ST_RUN, ST_STEP: begin
                    // halt is checked first so it wins over a coincident limit
                    if (cpu_en && halt) begin
                        state  <= ST_END;
                        cpu_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (cpu_en && limit_hit) begin
                        state   <= ST_END;
                        cpu_en  <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cpu_en <= (state == ST_RUN) ? 1'b1 : step;
                    end
                end
                ST_IDLE, ST_END: begin
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                    cpu_en    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
